uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart to the team's oversampling UART receiver, and uses the same frame format.
- Accepts one parallel word per valid/ready handshake.
- Serialises each word LSB-first as: start bit (0), DATA_WIDTH data bits, optional parity bit, STOP_BITS stop bits (1).
- Sits between a host-side producer (FIFO or CPU register) and the tx pin.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- DATA_WIDTH, 8, data bits per frame (legal range 5..9).
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored if PARITY_EN=0).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- tx_valid  in  1  producer has a word on tx_data.
- tx_data  in  DATA_WIDTH  word to send; sampled only on acceptance.
- tx_ready  out  1  block can accept a word this cycle.
- tx_serial  out  1  serial line output; idle level is 1.
- tx_busy  out  1  a frame is in progress (any state other than IDLE).
- tx_done  out  1  one-cycle pulse on the last clock of the final stop bit.

Behaviour:
- Timing constants:
  - CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division).
  - Elaboration error if CLKS_PER_BIT < 2.
  - Every bit, including start, parity and stop bits, holds for exactly CLKS_PER_BIT clocks.
- Reset (reset_n=0 at a rising edge):
  - State goes to IDLE.
  - tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
  - All counters and the shift register are cleared.
  - Reset mid-frame aborts the frame: the line returns to 1 on the edge that samples reset_n=0, and no tx_done is issued.
- Handshake:
  - A transfer occurs when tx_valid && tx_ready at a rising edge.
  - tx_data is latched into the shift register on that edge.
  - Parity is computed from the latched word: XOR-reduce, inverted when PARITY_ODD=1.
  - The start bit appears on tx_serial in the following cycle.
  - tx_ready is asserted in IDLE and in the last clock of the final stop bit; it is low at all other times.
  - tx_data and tx_valid are ignored while tx_ready=0.
- FSM states and transitions. "Bit end" means clk_count == CLKS_PER_BIT-1; clk_count clears at every bit end.
  - IDLE: tx_serial=1. Go to START on a transfer.
  - START: tx_serial=0. Go to DATA at bit end.
  - DATA: tx_serial = shift register bit 0. At each bit end, shift right and increment bit_count. After bit DATA_WIDTH-1, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: tx_serial = parity bit. Go to STOP at bit end.
  - STOP: tx_serial=1. stop_count counts 0..STOP_BITS-1. At bit end of the final stop bit:
    - tx_done=1.
    - If a transfer occurs in that same cycle, go to START (back-to-back frames with zero gap).
    - Otherwise go to IDLE.
- tx_serial is registered: driven from a flop, never combinationally from the inputs.
- Counter widths:
  - clk_count: $clog2(CLKS_PER_BIT).
  - bit_count: $clog2(DATA_WIDTH)+1.
  - stop_count: 1 bit.
  - Counters never wrap within a frame; each clears at its terminal value.
- tx_done and tx_ready may be high in the same cycle; tx_done is never asserted outside STOP.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - tx_ctrl_t packed struct of control points: {clk_en, clk_clr}, {bit_en, bit_clr}, {stop_en, stop_clr}, {shift_load, shift_en}, and tx_sel (2-bit line mux select: mark/space/data/parity).
- One sub-module, tx_datapath:
  - Contains the three counters (existing Counter module), a PISO shift register, the parity flop and the line output flop.
  - Exposes the status signals bit_end, last_data_bit and last_stop_bit.
- uart_tx itself contains the FSM and instantiates tx_datapath.

Test Plan:
- All scenarios use CLK_FREQ=1_000_000 and BAUD_RATE=100_000 (CLKS_PER_BIT=10) unless noted.
1. Basic frame: send 8'hA5, PARITY_EN=0 -> tx_serial reads 0,1,0,1,0,0,1,0,1,1, each bit held 10 clocks (100 clocks total). tx_done pulses exactly at clock 100 after acceptance; tx_busy is high throughout the frame.
2. Parity and two stop bits: PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, send 8'h07 -> parity bit = 1, 120 clocks total. With PARITY_ODD=1 -> parity bit = 0.
3. Back-to-back: hold tx_valid=1 with 8'h55 then 8'hAA -> the second start bit begins on the clock immediately after the first frame's final stop clock (no idle gap). Exactly two tx_ready&&tx_valid transfers occur.
4. Backpressure: pulse tx_valid with a new word during DATA -> no transfer; the frame on the line is unchanged and tx_ready stays 0 until the final stop clock.
5. Reset mid-frame: assert reset_n=0 during data bit 3 of 8'h00 -> tx_serial=1, tx_ready=1, tx_busy=0 on the next clock and no tx_done. A subsequent send of 8'hFF produces a clean, full frame.
6. Loopback: connect tx_serial to the team's UART receiver (same parameters, OVERSAMPLE=16, CLK_FREQ=100_000_000) and send 256 random words -> every received byte matches the sent byte, with no framing errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: FSM states, datapath
// control bundle and the frame parity function.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    SEL_MARK   = 2'd0,
    SEL_SPACE  = 2'd1,
    SEL_DATA   = 2'd2,
    SEL_PARITY = 2'd3
  } tx_sel_t;

  typedef struct packed {
    logic    clk_en;
    logic    clk_clr;
    logic    bit_en;
    logic    bit_clr;
    logic    stop_en;
    logic    stop_clr;
    logic    shift_load;
    logic    shift_en;
    tx_sel_t tx_sel;
  } tx_ctrl_t;

  localparam int MAX_DATA_WIDTH = 9;

  // Zero-extension of a narrower word does not change its XOR reduction.
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] word,
                                       input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/counter.sv
// Up-counter with synchronous clear (priority over enable) and synchronous
// active-low reset.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_clr) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tx_datapath.sv
// UART transmit datapath: bit-timing, data-bit and stop-bit counters, PISO
// shift register, parity flop and the registered line driver.
module tx_datapath
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  tx_ctrl_t              i_ctrl,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_bit_end,
  output logic                  o_last_data_bit,
  output logic                  o_last_stop_bit,
  output logic                  o_serial
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH) + 1;

  logic [CW-1:0]         w_clk_count;
  logic [BW-1:0]         w_bit_count;
  logic [0:0]            w_stop_count;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  r_parity;
  logic                  r_serial;
  logic                  w_serial_next;

  counter #(.WIDTH(CW)) u_clk_count (
    .clock   (clock),
    .reset_n (reset_n),
    .i_en    (i_ctrl.clk_en),
    .i_clr   (i_ctrl.clk_clr),
    .o_count (w_clk_count)
  );

  counter #(.WIDTH(BW)) u_bit_count (
    .clock   (clock),
    .reset_n (reset_n),
    .i_en    (i_ctrl.bit_en),
    .i_clr   (i_ctrl.bit_clr),
    .o_count (w_bit_count)
  );

  counter #(.WIDTH(1)) u_stop_count (
    .clock   (clock),
    .reset_n (reset_n),
    .i_en    (i_ctrl.stop_en),
    .i_clr   (i_ctrl.stop_clr),
    .o_count (w_stop_count)
  );

  assign o_bit_end       = (w_clk_count == CW'(CLKS_PER_BIT - 1));
  assign o_last_data_bit = (w_bit_count == BW'(DATA_WIDTH - 1));
  assign o_last_stop_bit = (w_stop_count == 1'(STOP_BITS - 1));

  // The line mux reads the post-edge shift value, so each data bit reaches
  // the output flop on the same edge the register moves.
  always_comb begin
    w_shift_next = r_shift;
    if (i_ctrl.shift_load) begin
      w_shift_next = i_data;
    end else if (i_ctrl.shift_en) begin
      w_shift_next = {1'b0, r_shift[DATA_WIDTH-1:1]};
    end else begin
      w_shift_next = r_shift;
    end
  end

  // Shift register and parity of the accepted word.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_shift  <= {DATA_WIDTH{1'b0}};
      r_parity <= 1'b0;
    end else begin
      r_shift <= w_shift_next;
      if (i_ctrl.shift_load) begin
        r_parity <= calc_parity(MAX_DATA_WIDTH'(i_data), 1'(PARITY_ODD));
      end else begin
        r_parity <= r_parity;
      end
    end
  end

  // Line level selected by the FSM for the coming cycle.
  always_comb begin
    w_serial_next = 1'b1;
    case (i_ctrl.tx_sel)
      SEL_MARK:   w_serial_next = 1'b1;
      SEL_SPACE:  w_serial_next = 1'b0;
      SEL_DATA:   w_serial_next = w_shift_next[0];
      SEL_PARITY: w_serial_next = r_parity;
      default:    w_serial_next = 1'b1;
    endcase
  end

  // Output flop; the line idles (and resets) to mark.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_serial <= 1'b1;
    end else begin
      r_serial <= w_serial_next;
    end
  end

  assign o_serial = r_serial;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word intake, framing FSM and serial line
// output (start, LSB-first data, optional parity, 1 or 2 stop bits).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
      $error("uart_tx: DATA_WIDTH must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  tx_state_t r_state;
  tx_state_t w_state_next;
  tx_ctrl_t  w_ctrl;
  logic      w_bit_end;
  logic      w_last_data_bit;
  logic      w_last_stop_bit;
  logic      w_frame_end;
  logic      w_xfer;
  logic      r_busy;

  assign w_frame_end = (r_state == STOP) && w_bit_end && w_last_stop_bit;
  assign tx_ready    = (r_state == IDLE) || w_frame_end;
  assign w_xfer      = tx_valid && tx_ready;
  assign tx_done     = w_frame_end;
  assign tx_busy     = r_busy;

  // State register and busy flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != IDLE);
    end
  end

  // Next state and datapath controls; tx_sel names the line level of the
  // state being entered, since the line is registered.
  always_comb begin
    w_state_next  = r_state;
    w_ctrl        = '0;
    w_ctrl.tx_sel = SEL_MARK;
    case (r_state)
      IDLE: begin
        w_ctrl.clk_clr = 1'b1;
        if (w_xfer) begin
          w_state_next      = START;
          w_ctrl.shift_load = 1'b1;
          w_ctrl.bit_clr    = 1'b1;
          w_ctrl.stop_clr   = 1'b1;
          w_ctrl.tx_sel     = SEL_SPACE;
        end else begin
          w_ctrl.tx_sel = SEL_MARK;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next   = DATA;
          w_ctrl.clk_clr = 1'b1;
          w_ctrl.tx_sel  = SEL_DATA;
        end else begin
          w_ctrl.clk_en = 1'b1;
          w_ctrl.tx_sel = SEL_SPACE;
        end
      end
      DATA: begin
        w_ctrl.tx_sel = SEL_DATA;
        if (w_bit_end) begin
          w_ctrl.clk_clr  = 1'b1;
          w_ctrl.shift_en = 1'b1;
          if (w_last_data_bit) begin
            w_ctrl.bit_clr = 1'b1;
            if (PARITY_EN != 0) begin
              w_state_next  = PARITY;
              w_ctrl.tx_sel = SEL_PARITY;
            end else begin
              w_state_next  = STOP;
              w_ctrl.tx_sel = SEL_MARK;
            end
          end else begin
            w_ctrl.bit_en = 1'b1;
          end
        end else begin
          w_ctrl.clk_en = 1'b1;
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_next   = STOP;
          w_ctrl.clk_clr = 1'b1;
          w_ctrl.tx_sel  = SEL_MARK;
        end else begin
          w_ctrl.clk_en = 1'b1;
          w_ctrl.tx_sel = SEL_PARITY;
        end
      end
      STOP: begin
        w_ctrl.tx_sel = SEL_MARK;
        if (w_bit_end) begin
          w_ctrl.clk_clr = 1'b1;
          if (w_last_stop_bit) begin
            w_ctrl.stop_clr = 1'b1;
            // A word accepted on the final stop clock starts with no gap.
            if (w_xfer) begin
              w_state_next      = START;
              w_ctrl.shift_load = 1'b1;
              w_ctrl.bit_clr    = 1'b1;
              w_ctrl.tx_sel     = SEL_SPACE;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_ctrl.stop_en = 1'b1;
          end
        end else begin
          w_ctrl.clk_en = 1'b1;
        end
      end
      default: begin
        w_state_next  = IDLE;
        w_ctrl.tx_sel = SEL_MARK;
      end
    endcase
  end

  tx_datapath #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_WIDTH   (DATA_WIDTH),
    .PARITY_ODD   (PARITY_ODD),
    .STOP_BITS    (STOP_BITS)
  ) u_datapath (
    .clock           (clock),
    .reset_n         (reset_n),
    .i_ctrl          (w_ctrl),
    .i_data          (tx_data),
    .o_bit_end       (w_bit_end),
    .o_last_data_bit (w_last_data_bit),
    .o_last_stop_bit (w_last_stop_bit),
    .o_serial        (tx_serial)
  );

endmodule
